// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the parametrised register file.
//   DEF_DATA_W / DEF_NUM_REGS / DEF_NUM_RD : default geometry
//   ZERO_IDX                               : index of the hard-wired zero register
//   addr_width()                           : index width for a given register count
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int ZERO_IDX     = 0;

  // Index width for n registers. NUM_REGS is a power of two and at least 2,
  // so this is exact. The floor of 1 protects a degenerate single-entry file.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending bit per register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_en, wr_addr      : write-back clears the pending bit of wr_addr
//   rsv_en, rsv_addr    : issue sets the pending bit of rsv_addr
//   busy_q              : current scoreboard (state after the last edge)
//   busy_d              : scoreboard as it will be after the coming edge,
//                         used by the top for same-edge pending reads
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = addr_width(DEF_NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic [NUM_REGS-1:0] busy_q,
  output logic [NUM_REGS-1:0] busy_d
);

  // Clear before set: when the retiring writer and a new issuer name the
  // same register on one edge, the new producer still owns it afterwards.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    busy_d = busy_q;
    if (wr_en)  busy_d[wr_addr]  = 1'b0;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// regfile_sb: register file with registered read ports, same-edge write
// bypass and a per-register pending-write scoreboard.
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : write-back port (writes data, clears pending)
//   rsv_en/rsv_addr       : issue reservation (sets pending)
//   rd_addr               : NUM_RD packed indices, port k at [k*ADDR_W +: ADDR_W]
//   rd_data               : NUM_RD packed registered read data
//   rd_pending            : registered pending flag per read port
//   busy_mask             : scoreboard after the most recent edge
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = DEF_NUM_RD,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = addr_width(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  output logic [NUM_REGS-1:0]      busy_mask
);

  logic [DATA_W-1:0]        mem_q [NUM_REGS];
  logic [DATA_W-1:0]        mem_d [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_pending_q, rd_pending_d;
  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic                     wr_hit;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_q   (busy_q),
    .busy_d   (busy_d)
  );

  // Writes to the zero register are dropped, so its storage stays at the
  // reset value of 0 and reads of it need no extra masking.
  assign wr_hit = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_IDX)));

  always_comb begin
    mem_d = mem_q;
    if (wr_hit) mem_d[wr_addr] = wr_data;
  end

  // Reads look at the post-edge image (mem_d / busy_d); that is what gives
  // write bypass and same-edge reserve/clear visibility for free.
  always_comb begin
    rd_data_d    = '0;
    rd_pending_d = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_d[k*DATA_W +: DATA_W] = mem_d[rd_addr[k*ADDR_W +: ADDR_W]];
      rd_pending_d[k]               = busy_d[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data array is reset on purpose: reset must present an
      // all-zero file, so this storage maps to flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      rd_data_q    <= '0;
      rd_pending_q <= '0;
    end else begin
      mem_q        <= mem_d;
      rd_data_q    <= rd_data_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_pending = rd_pending_q;
  assign busy_mask  = busy_q;

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven bench with an expected-result queue for the
// default 32x32, two-port register file, plus hand sequences for reset and a
// 16-bit, 8-entry, three-port build with a writable register 0.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;

  // Default-geometry instance
  logic        wr_en, rsv_en;
  logic [4:0]  wr_addr, rsv_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic [31:0] busy_mask;

  // Small instance: DATA_W=16, NUM_REGS=8, NUM_RD=3, ZERO_REG=0
  logic        s_wr_en, s_rsv_en;
  logic [2:0]  s_wr_addr, s_rsv_addr;
  logic [15:0] s_wr_data;
  logic [8:0]  s_rd_addr;
  logic [47:0] s_rd_data;
  logic [2:0]  s_rd_pending;
  logic [7:0]  s_busy_mask;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_sb u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .busy_mask  (busy_mask)
  );

  regfile_sb #(
    .DATA_W   (16),
    .NUM_REGS (8),
    .NUM_RD   (3),
    .ZERO_REG (0)
  ) u_dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (s_wr_en),
    .wr_addr    (s_wr_addr),
    .wr_data    (s_wr_data),
    .rsv_en     (s_rsv_en),
    .rsv_addr   (s_rsv_addr),
    .rd_addr    (s_rd_addr),
    .rd_data    (s_rd_data),
    .rd_pending (s_rd_pending),
    .busy_mask  (s_busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  ep;   // {port1, port0}
    logic [31:0] eb;
  } vec_t;

  typedef struct {
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  ep;
    logic [31:0] eb;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive one vector, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    wr_en    = v.wr_en;
    wr_addr  = v.wr_addr;
    wr_data  = v.wr_data;
    rsv_en   = v.rsv_en;
    rsv_addr = v.rsv_addr;
    rd_addr  = {v.ra1, v.ra0};
    exp_q.push_back('{v.ed0, v.ed1, v.ep, v.eb});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check($sformatf("v%0d queue_empty", idx), 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("v%0d rd_data0", idx),   {32'd0, rd_data[31:0]},  {32'd0, e.ed0});
      check($sformatf("v%0d rd_data1", idx),   {32'd0, rd_data[63:32]}, {32'd0, e.ed1});
      check($sformatf("v%0d rd_pending", idx), {62'd0, rd_pending},     {62'd0, e.ep});
      check($sformatf("v%0d busy_mask", idx),  {32'd0, busy_mask},      {32'd0, e.eb});
    end
  endtask

  initial begin
    // Expected values derived by hand from the register-file behaviour.
    //            wr  waddr  wdata          rsv raddr ra0    ra1    ed0            ed1            ep     eb
    vecs[0]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd3,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0};
    vecs[2]  = '{1'b1, 5'd3,  32'h11111111, 1'b0, 5'd0,  5'd0,  5'd3,  32'h0,        32'h11111111, 2'b00, 32'h0};
    vecs[3]  = '{1'b1, 5'd3,  32'h12345678, 1'b0, 5'd0,  5'd7,  5'd3,  32'hDEADBEEF, 32'h12345678, 2'b00, 32'h0};
    vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        2'b11, 32'h00000200};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd7,  32'h0,        32'hDEADBEEF, 2'b01, 32'h00000200};
    vecs[7]  = '{1'b1, 5'd9,  32'hCAFEF00D, 1'b0, 5'd0,  5'd9,  5'd3,  32'hCAFEF00D, 32'h12345678, 2'b00, 32'h0};
    vecs[8]  = '{1'b1, 5'd9,  32'h0BADF00D, 1'b1, 5'd9,  5'd9,  5'd9,  32'h0BADF00D, 32'h0BADF00D, 2'b11, 32'h00000200};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd31, 5'd9,  32'h0,        32'h0BADF00D, 2'b11, 32'h80000200};
    vecs[10] = '{1'b1, 5'd31, 32'h55AA55AA, 1'b0, 5'd0,  5'd31, 5'd31, 32'h55AA55AA, 32'h55AA55AA, 2'b00, 32'h00000200};
    vecs[11] = '{1'b1, 5'd5,  32'h00000005, 1'b1, 5'd12, 5'd5,  5'd12, 32'h00000005, 32'h0,        2'b10, 32'h00001200};

    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rsv_en = 1'b0; s_rsv_addr = '0; s_rd_addr = '0;

    #2;
    check("por rd_data",    rd_data,              64'd0);
    check("por rd_pending", {62'd0, rd_pending},  64'd0);
    check("por busy_mask",  {32'd0, busy_mask},   64'd0);
    #10 rst_n = 1'b1;  // released at t=12, between edges

    for (int i = 0; i < 12; i++) apply(vecs[i], i);

    // Mid-cycle asynchronous reset with nonzero contents and pending bits,
    // with a write and a reservation held on the inputs while in reset.
    #2;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF0000;
    rsv_en = 1'b1; rsv_addr = 5'd6; rd_addr = {5'd6, 5'd5};
    rst_n = 1'b0;
    #1;
    check("async rst rd_data",    rd_data,             64'd0);
    check("async rst rd_pending", {62'd0, rd_pending}, 64'd0);
    check("async rst busy_mask",  {32'd0, busy_mask},  64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("held rst rd_data",   rd_data,            64'd0);
    check("held rst busy_mask", {32'd0, busy_mask}, 64'd0);
    #1 rst_n = 1'b1;
    begin
      vec_t v;
      v = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7, 32'h0, 32'h0, 2'b00, 32'h0};
      apply(v, 100);
      // First edge after release behaves normally.
      v = '{1'b1, 5'd6, 32'h0000BEEF, 1'b1, 5'd6, 5'd6, 5'd5, 32'h0000BEEF, 32'h0, 2'b01, 32'h00000040};
      apply(v, 101);
    end
    wr_en = 1'b0; rsv_en = 1'b0;

    // Small build: write r7 then read it on all three ports.
    s_wr_en = 1'b1; s_wr_addr = 3'd7; s_wr_data = 16'hA5A5;
    @(posedge clk); #1;
    s_wr_en = 1'b0; s_rd_addr = {3'd7, 3'd7, 3'd7};
    @(posedge clk); #1;
    check("small p0 r7", {48'd0, s_rd_data[15:0]},  64'h A5A5);
    check("small p1 r7", {48'd0, s_rd_data[31:16]}, 64'h A5A5);
    check("small p2 r7", {48'd0, s_rd_data[47:32]}, 64'h A5A5);
    check("small pending r7", {61'd0, s_rd_pending}, 64'd0);

    // Register 0 is an ordinary register in this build: bypass and reserve.
    s_wr_en = 1'b1; s_wr_addr = 3'd0; s_wr_data = 16'h1234;
    s_rsv_en = 1'b1; s_rsv_addr = 3'd0; s_rd_addr = {3'd7, 3'd0, 3'd0};
    @(posedge clk); #1;
    s_wr_en = 1'b0; s_rsv_en = 1'b0;
    check("small p0 r0", {48'd0, s_rd_data[15:0]},  64'h1234);
    check("small p1 r0", {48'd0, s_rd_data[31:16]}, 64'h1234);
    check("small p2 r7b", {48'd0, s_rd_data[47:32]}, 64'hA5A5);
    check("small pending r0", {61'd0, s_rd_pending}, 64'b011);
    check("small busy_mask",  {56'd0, s_busy_mask},  64'h01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_regfile_sb
